// File: rtl/vregfile_banked_if.sv
// Write-request and read-port bundle of the banked vector register file.
// The requester side drives addresses, data and valids; the VRF answers.
interface vregfile_banked_if #(
  parameter int unsigned NrReadPorts  = 3,
  parameter int unsigned NrWritePorts = 2,
  parameter int unsigned NrWords      = 32,
  parameter int unsigned WordWidth    = 64
);
  localparam int unsigned AW = $clog2(NrWords);
  localparam int unsigned NB = WordWidth / 8;

  logic [NrWritePorts-1:0][AW-1:0]        waddr;
  logic [NrWritePorts-1:0][WordWidth-1:0] wdata;
  logic [NrWritePorts-1:0][NB-1:0]        wbe;
  logic [NrWritePorts-1:0]                wvalid;
  logic [NrWritePorts-1:0]                wready;
  logic [NrReadPorts-1:0][AW-1:0]         raddr;
  logic [NrReadPorts-1:0][WordWidth-1:0]  rdata;

  modport master (
    output waddr, wdata, wbe, wvalid, raddr,
    input  wready, rdata
  );

  modport slave (
    input  waddr, wdata, wbe, wvalid, raddr,
    output wready, rdata
  );
endinterface

// File: rtl/vregfile_banked.sv
// Banked flop VRF: per-bank round-robin write arbiter, one-stage
// write pipeline, optional stage-to-read bypass, synchronous clear.
module vregfile_banked #(
  parameter int unsigned NrReadPorts  = 3,
  parameter int unsigned NrWritePorts = 2,
  parameter int unsigned NrWords      = 32,
  parameter int unsigned WordWidth    = 64,
  parameter int unsigned NrBanks      = 4,
  parameter bit          Bypass       = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  vregfile_banked_if.slave  bus
);
  localparam int unsigned AW = $clog2(NrWords);
  localparam int unsigned NB = WordWidth / 8;
  localparam int unsigned BW =
    (NrBanks > 1) ? $clog2(NrBanks) : 1;
  localparam int unsigned PW =
    (NrWritePorts > 1) ? $clog2(NrWritePorts) : 1;

  typedef logic [NB-1:0][7:0] word_t;

  word_t mem [NrWords];

  logic [NrBanks-1:0]          stg_valid;
  logic [NrBanks-1:0][AW-1:0]  stg_addr;
  word_t                       stg_data [NrBanks];
  logic [NrBanks-1:0][NB-1:0]  stg_be;

  logic [NrBanks-1:0][PW-1:0]  rr_q;
  logic [NrBanks-1:0][PW-1:0]  win_port;
  logic [NrBanks-1:0]          win_valid;
  logic [NrWritePorts-1:0]     grant;

  logic [NrReadPorts-1:0][NB-1:0][7:0] rd;

  function automatic logic [BW-1:0] bank_of(
    input logic [AW-1:0] a
  );
    return (NrBanks == 1) ? '0 : a[BW-1:0];
  endfunction

  // Search each bank's requesters upward from its pointer, with wrap.
  always_comb begin
    int p;
    p         = 0;
    grant     = '0;
    win_valid = '0;
    win_port  = '0;
    if (!rst_i) begin
      for (int b = 0; b < int'(NrBanks); b++) begin
        for (int k = 0; k < int'(NrWritePorts); k++) begin
          p = int'(rr_q[b]) + k;
          if (p >= int'(NrWritePorts))
            p = p - int'(NrWritePorts);
          if (!win_valid[b] && bus.wvalid[p] &&
              bank_of(bus.waddr[p]) == BW'(b)) begin
            win_valid[b] = 1'b1;
            win_port[b]  = PW'(p);
            grant[p]     = 1'b1;
          end
        end
      end
    end
  end

  assign bus.wready = grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_valid <= '0;
      rr_q      <= '0;
      for (int w = 0; w < int'(NrWords); w++)
        mem[w] <= '0;
    end else begin
      stg_valid <= win_valid;
      for (int b = 0; b < int'(NrBanks); b++) begin
        if (win_valid[b]) begin
          stg_addr[b] <= bus.waddr[win_port[b]];
          stg_data[b] <= bus.wdata[win_port[b]];
          stg_be[b]   <= bus.wbe[win_port[b]];
          rr_q[b]     <=
            (win_port[b] == PW'(NrWritePorts - 1)) ?
            '0 : win_port[b] + 1'b1;
        end
      end
      for (int b = 0; b < int'(NrBanks); b++) begin
        if (stg_valid[b]) begin
          for (int i = 0; i < int'(NB); i++) begin
            if (stg_be[b][i])
              mem[stg_addr[b]][i] <= stg_data[b][i];
          end
        end
      end
    end
  end

  // Bypass merges only registered stage bytes over the stored word.
  always_comb begin
    logic [BW-1:0] rb;
    rb = '0;
    rd = '0;
    for (int r = 0; r < int'(NrReadPorts); r++) begin
      rd[r] = mem[bus.raddr[r]];
      if (Bypass) begin
        rb = bank_of(bus.raddr[r]);
        if (stg_valid[rb] && stg_addr[rb] == bus.raddr[r]) begin
          for (int i = 0; i < int'(NB); i++) begin
            if (stg_be[rb][i])
              rd[r][i] = stg_data[rb][i];
          end
        end
      end
    end
  end

  assign bus.rdata = rd;

endmodule

// File: tb/tb_vregfile_banked.sv
// Directed bench: a bypass and a non-bypass instance see the same
// stimulus; expected values are hand-computed constants.
module tb_vregfile_banked;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vregfile_banked_if #(3, 2, 32, 64) b1 ();
  vregfile_banked_if #(3, 2, 32, 64) b0 ();

  assign b0.waddr  = b1.waddr;
  assign b0.wdata  = b1.wdata;
  assign b0.wbe    = b1.wbe;
  assign b0.wvalid = b1.wvalid;
  assign b0.raddr  = b1.raddr;

  vregfile_banked #(
    .NrReadPorts(3), .NrWritePorts(2), .NrWords(32),
    .WordWidth(64), .NrBanks(4), .Bypass(1'b1)
  ) dut_byp (
    .clk_i(clk), .rst_i(rst), .bus(b1.slave)
  );

  vregfile_banked #(
    .NrReadPorts(3), .NrWritePorts(2), .NrWords(32),
    .WordWidth(64), .NrBanks(4), .Bypass(1'b0)
  ) dut_nob (
    .clk_i(clk), .rst_i(rst), .bus(b0.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] D1   = 64'h1122334455667788;
  localparam logic [63:0] DA   = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] D5   = 64'h5555555555555555;
  localparam logic [63:0] DM   = 64'hAAAAAAAA55555555;
  localparam logic [63:0] DX   = 64'hDEADBEEFCAFEF00D;

  logic [1:0] rr_exp [4];

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request from a single port; returns in the stage cycle.
  task automatic wr1(
    input int          port,
    input logic [4:0]  addr,
    input logic [63:0] data,
    input logic [7:0]  be
  );
    b1.wvalid       = '0;
    b1.wvalid[port] = 1'b1;
    b1.waddr[port]  = addr;
    b1.wdata[port]  = data;
    b1.wbe[port]    = be;
    #1;
    check("wr1_rdy", 64'(b1.wready), 64'(2'b01 << port));
    tick();
    b1.wvalid = '0;
  endtask

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    b1.waddr  = '0;
    b1.wdata  = '0;
    b1.wbe    = '0;
    b1.raddr  = '0;
    b1.wvalid = 2'b11;
    b1.waddr[1] = 5'd1;
    #1;
    check("rdy_in_rst", 64'(b1.wready), 64'd0);
    tick();
    rst = 1'b0;
    b1.wvalid = '0;
    #1;
    check("rd_after_rst", b1.rdata[0], 64'd0);

    // Preload then clear
    wr1(0, 5'd5, ONES, 8'hFF);
    tick();
    b1.raddr[0] = 5'd5;
    #1;
    check("preload5", b1.rdata[0], ONES);
    rst = 1'b1;
    b1.wvalid = 2'b11;
    b1.waddr[0] = 5'd5;
    b1.waddr[1] = 5'd6;
    #1;
    check("rdy_rst2", 64'(b1.wready), 64'd0);
    tick();
    rst = 1'b0;
    b1.wvalid = '0;
    #1;
    check("clr5", b1.rdata[0], 64'd0);
    for (int w = 0; w < 32; w++) begin
      b1.raddr[0] = 5'(w);
      #1;
      check("clr_all", b1.rdata[0], 64'd0);
    end

    // Single write latency
    b1.raddr[0] = 5'd3;
    wr1(0, 5'd3, D1, 8'hFF);
    #1;
    check("lat_byp_c1", b1.rdata[0], D1);
    check("lat_nob_c1", b0.rdata[0], 64'd0);
    tick();
    check("lat_nob_c2", b0.rdata[0], D1);
    check("lat_byp_c2", b1.rdata[0], D1);

    // Same-bank conflict then disjoint banks
    b1.wvalid   = 2'b11;
    b1.waddr[0] = 5'd4;
    b1.waddr[1] = 5'd8;
    b1.wbe      = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_conf", 64'(b1.wready), 64'(rr_exp[i]));
      tick();
    end
    b1.waddr[1] = 5'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_par", 64'(b1.wready), 64'd3);
      tick();
    end
    b1.wvalid = '0;
    tick();

    // Byte-enable merge
    b1.raddr[1] = 5'd7;
    wr1(1, 5'd7, DA, 8'hFF);
    tick();
    wr1(1, 5'd7, D5, 8'h0F);
    #1;
    check("be_byp_c1", b1.rdata[1], DM);
    check("be_nob_c1", b0.rdata[1], DA);
    tick();
    check("be_nob_c2", b0.rdata[1], DM);

    // Zero byte-enable commits nothing
    wr1(0, 5'd7, 64'd0, 8'h00);
    #1;
    check("be0_byp", b1.rdata[1], DM);
    tick();
    check("be0_mem", b0.rdata[1], DM);

    // Same-address back-to-back ordering
    b1.raddr[2] = 5'd2;
    b1.wvalid   = 2'b01;
    b1.waddr[0] = 5'd2;
    b1.wdata[0] = 64'd1;
    b1.wbe[0]   = 8'hFF;
    #1;
    check("waw_rdy0", 64'(b1.wready), 64'd1);
    tick();
    b1.wdata[0] = 64'd2;
    #1;
    check("waw_rdy1", 64'(b1.wready), 64'd1);
    check("waw_byp1", b1.rdata[2], 64'd1);
    tick();
    b1.wvalid = '0;
    #1;
    check("waw_byp2", b1.rdata[2], 64'd2);
    check("waw_nob2", b0.rdata[2], 64'd1);
    tick();
    check("waw_fin", b0.rdata[2], 64'd2);

    // Reset while a write sits in the stage
    b1.raddr[0] = 5'd9;
    wr1(0, 5'd9, DX, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_byp", b1.rdata[0], 64'd0);
    check("mid_nob", b0.rdata[0], 64'd0);
    b1.wvalid   = 2'b11;
    b1.waddr[0] = 5'd9;
    b1.waddr[1] = 5'd13;
    #1;
    check("mid_rr", 64'(b1.wready), 64'd1);
    tick();
    b1.wvalid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
